// File: rtl/ex_mem_nlane.sv
// EX/MEM pipeline register for an N-issue in-order core.
// Lane 0 owns the memory/HI-LO slot; saturating event counters included.
module ex_mem_nlane #(
   parameter int              LANES     = 2,
   parameter int              ADDR_W    = 32,
   parameter int              DATA_W    = 32,
   parameter int              AOP_W     = 8,
   parameter int              STAGE_IDX = 1,
   parameter int              STALL_W   = 6,
   parameter logic [AOP_W-1:0] NOP_OP   = '0,
   parameter int              CNT_W     = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     flush_cause,
   input  logic [STALL_W-1:0]       stall,
   input  logic [LANES-1:0]         valid_i,
   input  logic [LANES-1:0]         kill_i,
   input  logic [LANES*ADDR_W-1:0]  inst_addr_i,
   input  logic [LANES*5-1:0]       waddr_i,
   input  logic [LANES-1:0]         we_i,
   input  logic [LANES*DATA_W-1:0]  wdata_i,
   input  logic [DATA_W-1:0]        hi_i,
   input  logic [DATA_W-1:0]        lo_i,
   input  logic                     whilo_i,
   input  logic [AOP_W-1:0]         aluop_i,
   input  logic [DATA_W-1:0]        mem_addr_i,
   input  logic [DATA_W-1:0]        reg2_i,
   input  logic                     cnt_clr,
   output logic [LANES-1:0]         valid_o,
   output logic [LANES*ADDR_W-1:0]  inst_addr_o,
   output logic [LANES*5-1:0]       waddr_o,
   output logic [LANES-1:0]         we_o,
   output logic [LANES*DATA_W-1:0]  wdata_o,
   output logic [DATA_W-1:0]        hi_o,
   output logic [DATA_W-1:0]        lo_o,
   output logic                     whilo_o,
   output logic [AOP_W-1:0]         aluop_o,
   output logic [DATA_W-1:0]        mem_addr_o,
   output logic [DATA_W-1:0]        reg2_o,
   output logic [CNT_W-1:0]         hold_cnt_o,
   output logic [CNT_W-1:0]         bubble_cnt_o,
   output logic [CNT_W-1:0]         retire_cnt_o
);

   localparam int SUM_W = CNT_W + 3;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      ACT_FLUSH,
      ACT_BUBBLE,
      ACT_ADV,
      ACT_HOLD
   } act_t;

   act_t                    act;
   logic                    up;
   logic                    dn;
   logic                    stall_unused;
   logic [LANES-1:0]        live;
   logic [LANES*ADDR_W-1:0] cap_inst;
   logic [LANES*5-1:0]      cap_waddr;
   logic [LANES*DATA_W-1:0] cap_wdata;
   logic [2:0]              pop;
   logic [SUM_W-1:0]        ret_sum;
   logic [CNT_W-1:0]        ret_nxt;

   assign up           = stall[STAGE_IDX];
   assign dn           = stall[STAGE_IDX+1];
   assign stall_unused = ^stall;
   assign live         = valid_i & ~kill_i;

   // up=0 with dn=1 cannot legally occur; it falls through to advance
   always_comb begin
      act = ACT_HOLD;
      if (flush && flush_cause)
         act = ACT_FLUSH;
      else if (up && !dn)
         act = ACT_BUBBLE;
      else if (!up)
         act = ACT_ADV;
   end

   always_comb begin
      cap_inst  = '0;
      cap_waddr = '0;
      cap_wdata = '0;
      pop       = '0;
      for (int k = 0; k < LANES; k++) begin
         pop = pop + 3'(live[k]);
         if (live[k]) begin
            cap_inst[k*ADDR_W +: ADDR_W]  = inst_addr_i[k*ADDR_W +: ADDR_W];
            cap_waddr[k*5 +: 5]           = waddr_i[k*5 +: 5];
            cap_wdata[k*DATA_W +: DATA_W] = wdata_i[k*DATA_W +: DATA_W];
         end
      end
   end

   assign ret_sum = SUM_W'(retire_cnt_o) + SUM_W'(pop);
   assign ret_nxt = (ret_sum > SUM_W'(CNT_MAX)) ? CNT_MAX
                                                : ret_sum[CNT_W-1:0];

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_o     <= '0;
         inst_addr_o <= '0;
         waddr_o     <= '0;
         we_o        <= '0;
         wdata_o     <= '0;
         hi_o        <= '0;
         lo_o        <= '0;
         whilo_o     <= 1'b0;
         aluop_o     <= NOP_OP;
         mem_addr_o  <= '0;
         reg2_o      <= '0;
      end else begin
         case (act)
            ACT_FLUSH, ACT_BUBBLE: begin
               valid_o     <= '0;
               inst_addr_o <= '0;
               waddr_o     <= '0;
               we_o        <= '0;
               wdata_o     <= '0;
               hi_o        <= '0;
               lo_o        <= '0;
               whilo_o     <= 1'b0;
               aluop_o     <= NOP_OP;
               mem_addr_o  <= '0;
               reg2_o      <= '0;
            end
            ACT_ADV: begin
               valid_o     <= live;
               inst_addr_o <= cap_inst;
               waddr_o     <= cap_waddr;
               we_o        <= live & we_i;
               wdata_o     <= cap_wdata;
               // the memory/HI-LO slot travels with lane 0 only
               hi_o        <= live[0] ? hi_i : '0;
               lo_o        <= live[0] ? lo_i : '0;
               whilo_o     <= live[0] & whilo_i;
               aluop_o     <= live[0] ? aluop_i : NOP_OP;
               mem_addr_o  <= live[0] ? mem_addr_i : '0;
               reg2_o      <= live[0] ? reg2_i : '0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_cnt_o   <= '0;
         bubble_cnt_o <= '0;
         retire_cnt_o <= '0;
      end else if (cnt_clr) begin
         hold_cnt_o   <= '0;
         bubble_cnt_o <= '0;
         retire_cnt_o <= '0;
      end else begin
         case (act)
            ACT_BUBBLE: bubble_cnt_o <= sat_inc(bubble_cnt_o);
            ACT_ADV:    retire_cnt_o <= ret_nxt;
            ACT_HOLD:   hold_cnt_o   <= sat_inc(hold_cnt_o);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_mem_nlane.sv
// Randomised bench for ex_mem_nlane against a behavioural stage model.
// Directed scenarios first, then a random walk over stall/flush/kill.
module tb_ex_mem_nlane;

   localparam int              LANES     = 2;
   localparam int              ADDR_W    = 32;
   localparam int              DATA_W    = 32;
   localparam int              AOP_W     = 8;
   localparam int              STAGE_IDX = 1;
   localparam int              STALL_W   = 6;
   localparam logic [AOP_W-1:0] NOP      = 8'h5A;
   localparam int              CNT_W     = 4;
   localparam int              CMAX      = (1 << CNT_W) - 1;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    flush;
   logic                    flush_cause;
   logic [STALL_W-1:0]      stall;
   logic [LANES-1:0]        valid_i;
   logic [LANES-1:0]        kill_i;
   logic [LANES*ADDR_W-1:0] inst_addr_i;
   logic [LANES*5-1:0]      waddr_i;
   logic [LANES-1:0]        we_i;
   logic [LANES*DATA_W-1:0] wdata_i;
   logic [DATA_W-1:0]       hi_i;
   logic [DATA_W-1:0]       lo_i;
   logic                    whilo_i;
   logic [AOP_W-1:0]        aluop_i;
   logic [DATA_W-1:0]       mem_addr_i;
   logic [DATA_W-1:0]       reg2_i;
   logic                    cnt_clr;
   logic [LANES-1:0]        valid_o;
   logic [LANES*ADDR_W-1:0] inst_addr_o;
   logic [LANES*5-1:0]      waddr_o;
   logic [LANES-1:0]        we_o;
   logic [LANES*DATA_W-1:0] wdata_o;
   logic [DATA_W-1:0]       hi_o;
   logic [DATA_W-1:0]       lo_o;
   logic                    whilo_o;
   logic [AOP_W-1:0]        aluop_o;
   logic [DATA_W-1:0]       mem_addr_o;
   logic [DATA_W-1:0]       reg2_o;
   logic [CNT_W-1:0]        hold_cnt_o;
   logic [CNT_W-1:0]        bubble_cnt_o;
   logic [CNT_W-1:0]        retire_cnt_o;

   ex_mem_nlane #(
      .LANES(LANES), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .AOP_W(AOP_W),
      .STAGE_IDX(STAGE_IDX), .STALL_W(STALL_W), .NOP_OP(NOP), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush), .flush_cause(flush_cause),
      .stall(stall), .valid_i(valid_i), .kill_i(kill_i),
      .inst_addr_i(inst_addr_i), .waddr_i(waddr_i), .we_i(we_i),
      .wdata_i(wdata_i), .hi_i(hi_i), .lo_i(lo_i), .whilo_i(whilo_i),
      .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
      .cnt_clr(cnt_clr), .valid_o(valid_o), .inst_addr_o(inst_addr_o),
      .waddr_o(waddr_o), .we_o(we_o), .wdata_o(wdata_o), .hi_o(hi_o),
      .lo_o(lo_o), .whilo_o(whilo_o), .aluop_o(aluop_o),
      .mem_addr_o(mem_addr_o), .reg2_o(reg2_o), .hold_cnt_o(hold_cnt_o),
      .bubble_cnt_o(bubble_cnt_o), .retire_cnt_o(retire_cnt_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (!rst)
         assert (!(stall[STAGE_IDX] == 1'b0 && stall[STAGE_IDX+1] == 1'b1))
         else $error("FAIL illegal_stall up=0 dn=1");

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // model of the visible stage state
   logic [LANES-1:0]        m_valid, m_we;
   logic [LANES*ADDR_W-1:0] m_inst;
   logic [LANES*5-1:0]      m_waddr;
   logic [LANES*DATA_W-1:0] m_wdata;
   logic [DATA_W-1:0]       m_hi, m_lo, m_maddr, m_reg2;
   logic                    m_whilo;
   logic [AOP_W-1:0]        m_aluop;
   int                      m_hold, m_bubble, m_retire;

   task automatic m_empty();
      m_valid = '0; m_we = '0; m_inst = '0; m_waddr = '0; m_wdata = '0;
      m_hi = '0; m_lo = '0; m_maddr = '0; m_reg2 = '0;
      m_whilo = 1'b0; m_aluop = NOP;
   endtask

   task automatic m_reset();
      m_empty();
      m_hold = 0; m_bubble = 0; m_retire = 0;
   endtask

   task automatic m_edge();
      bit up, dn;
      int n;
      up = stall[STAGE_IDX];
      dn = stall[STAGE_IDX+1];
      n = 0;
      if (flush && flush_cause) begin
         m_empty();
      end else if (up && !dn) begin
         m_empty();
         m_bubble = (m_bubble < CMAX) ? m_bubble + 1 : CMAX;
      end else if (!up) begin
         m_empty();
         for (int k = 0; k < LANES; k++) begin
            if (valid_i[k] && !kill_i[k]) begin
               n++;
               m_valid[k] = 1'b1;
               m_we[k]    = we_i[k];
               m_inst[k*ADDR_W +: ADDR_W]  = inst_addr_i[k*ADDR_W +: ADDR_W];
               m_waddr[k*5 +: 5]           = waddr_i[k*5 +: 5];
               m_wdata[k*DATA_W +: DATA_W] = wdata_i[k*DATA_W +: DATA_W];
               if (k == 0) begin
                  m_hi = hi_i; m_lo = lo_i; m_whilo = whilo_i;
                  m_aluop = aluop_i; m_maddr = mem_addr_i; m_reg2 = reg2_i;
               end
            end
         end
         m_retire = (m_retire + n > CMAX) ? CMAX : m_retire + n;
      end else begin
         m_hold = (m_hold < CMAX) ? m_hold + 1 : CMAX;
      end
      if (cnt_clr) begin
         m_hold = 0; m_bubble = 0; m_retire = 0;
      end
   endtask

   task automatic check_all(input string p);
      chk({p, "_valid"}, 64'(valid_o), 64'(m_valid));
      chk({p, "_inst"}, 64'(inst_addr_o), 64'(m_inst));
      chk({p, "_waddr"}, 64'(waddr_o), 64'(m_waddr));
      chk({p, "_we"}, 64'(we_o), 64'(m_we));
      chk({p, "_wdata"}, 64'(wdata_o), 64'(m_wdata));
      chk({p, "_hi"}, 64'(hi_o), 64'(m_hi));
      chk({p, "_lo"}, 64'(lo_o), 64'(m_lo));
      chk({p, "_whilo"}, 64'(whilo_o), 64'(m_whilo));
      chk({p, "_aluop"}, 64'(aluop_o), 64'(m_aluop));
      chk({p, "_maddr"}, 64'(mem_addr_o), 64'(m_maddr));
      chk({p, "_reg2"}, 64'(reg2_o), 64'(m_reg2));
      chk({p, "_hold"}, 64'(hold_cnt_o), 64'(m_hold));
      chk({p, "_bubble"}, 64'(bubble_cnt_o), 64'(m_bubble));
      chk({p, "_retire"}, 64'(retire_cnt_o), 64'(m_retire));
   endtask

   task automatic cycle(input string p);
      @(posedge clk);
      m_edge();
      #1;
      check_all(p);
   endtask

   task automatic rand_payload();
      inst_addr_i = {$urandom, $urandom};
      waddr_i     = 10'($urandom);
      we_i        = 2'($urandom);
      wdata_i     = {$urandom, $urandom};
      hi_i        = $urandom;
      lo_i        = $urandom;
      whilo_i     = 1'($urandom);
      aluop_i     = 8'($urandom);
      mem_addr_i  = $urandom;
      reg2_i      = $urandom;
   endtask

   task automatic rand_all();
      int s;
      rand_payload();
      valid_i = 2'($urandom);
      kill_i  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      s = $urandom_range(0, 9);
      stall = 6'($urandom) & 6'b111001;
      if (s < 2)      stall = stall | 6'b000010;
      else if (s < 4) stall = stall | 6'b000110;
      flush       = ($urandom_range(0, 7) == 0);
      flush_cause = 1'($urandom);
      cnt_clr     = ($urandom_range(0, 11) == 0);
   endtask

   initial begin
      int r0;
      rst = 1'b1; flush = 0; flush_cause = 0; stall = '0; cnt_clr = 0;
      valid_i = '0; kill_i = '0; rand_payload();
      m_reset();
      #1;
      check_all("reset");
      @(negedge clk);
      rst = 1'b0;

      // advance both lanes
      valid_i = 2'b11; kill_i = 2'b00;
      inst_addr_i = {32'hBFC0_0004, 32'hBFC0_0000};
      aluop_i = 8'h21;
      cycle("t1");
      chk("t1_valid_k", 64'(valid_o), 64'h3);
      chk("t1_inst_k", 64'(inst_addr_o), 64'hBFC0_0004_BFC0_0000);
      chk("t1_aluop_k", 64'(aluop_o), 64'h21);
      chk("t1_ret_k", 64'(retire_cnt_o), 64'd2);

      // bubble
      stall = 6'b000010; rand_payload();
      cycle("t2");
      chk("t2_aluop_k", 64'(aluop_o), 64'(NOP));
      chk("t2_bub_k", 64'(bubble_cnt_o), 64'd1);
      chk("t2_ret_k", 64'(retire_cnt_o), 64'd2);

      // refill, then hold three cycles under changing inputs
      stall = '0; aluop_i = 8'h21;
      inst_addr_i = {32'hBFC0_0004, 32'hBFC0_0000};
      cycle("t3a");
      for (int i = 0; i < 3; i++) begin
         stall = 6'b000110; rand_payload(); valid_i = 2'($urandom);
         cycle("t3h");
      end
      chk("t3_hold_k", 64'(hold_cnt_o), 64'd3);
      chk("t3_inst_k", 64'(inst_addr_o), 64'hBFC0_0004_BFC0_0000);
      stall = '0; valid_i = 2'b11; rand_payload();
      cycle("t3r");

      // exception flush during hold, then branch flush during hold
      stall = 6'b000110; flush = 1; flush_cause = 1; rand_payload();
      cycle("t4e");
      chk("t4_valid_k", 64'(valid_o), 64'h0);
      chk("t4_hold_k", 64'(hold_cnt_o), 64'd3);
      chk("t4_bub_k", 64'(bubble_cnt_o), 64'd1);
      flush = 0; stall = '0; valid_i = 2'b11; rand_payload();
      cycle("t4a");
      stall = 6'b000110; flush = 1; flush_cause = 0; rand_payload();
      cycle("t4b");
      chk("t4b_valid_k", 64'(valid_o), 64'h3);
      flush = 0;

      // kill lane 0: the lane-0 slot must come out empty
      stall = '0; rand_payload();
      valid_i = 2'b11; kill_i = 2'b01; we_i = 2'b11; whilo_i = 1;
      r0 = m_retire;
      cycle("t5");
      chk("t5_valid_k", 64'(valid_o), 64'h2);
      chk("t5_we_k", 64'(we_o), 64'h2);
      chk("t5_whilo_k", 64'(whilo_o), 64'h0);
      chk("t5_aluop_k", 64'(aluop_o), 64'(NOP));
      chk("t5_ret_k", 64'(retire_cnt_o), 64'(r0 + 1));
      kill_i = '0;

      // saturation then clear
      for (int i = 0; i < 20; i++) begin
         rand_payload(); valid_i = 2'b11;
         cycle("t6s");
      end
      chk("t6_sat_k", 64'(retire_cnt_o), 64'd15);
      cnt_clr = 1; rand_payload();
      cycle("t6c");
      chk("t6_clr_k", 64'(retire_cnt_o), 64'd0);
      cnt_clr = 0;

      // random walk
      for (int i = 0; i < 400; i++) begin
         rand_all();
         cycle("rnd");
      end

      // asynchronous reset mid-hold
      flush = 0; cnt_clr = 0; stall = '0; valid_i = 2'b11; rand_payload();
      cycle("t7a");
      stall = 6'b000110;
      cycle("t7h");
      #2;
      rst = 1'b1;
      #1;
      m_reset();
      check_all("t7rst");
      chk("t7_aluop_k", 64'(aluop_o), 64'(NOP));
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 100; i++) begin
         rand_all();
         cycle("rnd2");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ex_mem_nlane.md
Name: ex_mem_nlane

Overview:
Parametrised EX/MEM pipeline register for an N-issue in-order MIPS core, generalising the fixed dual-issue EX/MEM latch. It carries a payload per lane (PC, write address, write enable, write data) and a valid bit per lane. A single memory/HI-LO slot is bound to lane 0. It handles pipeline-wide stall, bubble, flush and per-lane kill, and keeps saturating performance counters for hold, bubble and retired-lane events.

Parameters:
LANES, 2, issue width (number of lanes); 1..4 supported
ADDR_W, 32, instruction address width
DATA_W, 32, register/data width
AOP_W, 8, ALU opcode width
STAGE_IDX, 1, index of this stage's upstream bit in the stall vector; the downstream bit is STAGE_IDX+1
STALL_W, 6, stall vector width; must be at least STAGE_IDX+2
NOP_OP, 8'h00, aluop value driven when the memory slot is empty
CNT_W, 32, performance counter width

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  asynchronous reset, active-high
flush  in  1  pipeline flush request
flush_cause  in  1  1 = exception flush (acted on here); 0 = branch flush (ignored here, handled upstream)
stall  in  STALL_W  pipeline stall vector
valid_i  in  LANES  lane valid from EX
kill_i  in  LANES  per-lane squash applied at capture
inst_addr_i  in  LANES*ADDR_W  packed lane PCs; lane k occupies bits [k*ADDR_W +: ADDR_W]
waddr_i  in  LANES*5  packed destination register addresses
we_i  in  LANES  register write enables
wdata_i  in  LANES*DATA_W  packed write data
hi_i, lo_i  in  DATA_W each  HI/LO write values (lane 0)
whilo_i  in  1  HI/LO write enable (lane 0)
aluop_i  in  AOP_W  lane-0 ALU opcode
mem_addr_i  in  DATA_W  lane-0 memory address
reg2_i  in  DATA_W  lane-0 store data
cnt_clr  in  1  synchronous clear of all counters
valid_o, inst_addr_o, waddr_o, we_o, wdata_o, hi_o, lo_o, whilo_o, aluop_o, mem_addr_o, reg2_o  out  widths as the matching inputs  registered stage outputs
hold_cnt_o  out  CNT_W  cycles spent holding
bubble_cnt_o  out  CNT_W  bubbles inserted (flushes excluded)
retire_cnt_o  out  CNT_W  valid lanes captured

Behaviour:
- Reset is asynchronous, active-high. On reset every output is 0, except aluop_o = NOP_OP. This includes all counters.
- Define up = stall[STAGE_IDX] and dn = stall[STAGE_IDX+1]. Evaluate once per rising edge with this priority:
  1. FLUSH when flush=1 and flush_cause=1. Load the empty state regardless of up/dn.
  2. BUBBLE when up=1 and dn=0. Load the empty state; bubble_cnt increments.
  3. ADVANCE when up=0. Capture the inputs; retire_cnt increments by popcount(valid_i & ~kill_i).
  4. HOLD when up=1 and dn=1. All payload registers keep their value; hold_cnt increments.
- A cycle with up=0 and dn=1 is illegal. It is treated as ADVANCE, and the bench asserts that it never occurs.
- Empty state: valid_o=0, we_o=0, whilo_o=0, aluop_o=NOP_OP, and every address/data output = 0.
- Capture rules, per lane k:
  - live_k = valid_i[k] & ~kill_i[k].
  - If live_k: valid_o[k]=1 and the lane fields are copied from the inputs.
  - If not live_k: the lane is zeroed and we_o[k]=0.
- Lane-0 slot (hi/lo/whilo/aluop/mem_addr/reg2) is captured only if live_0; otherwise it is loaded with the empty state.
- Branch flush (flush=1, flush_cause=0) has no effect; rows 2-4 apply as normal.
- Latency is one cycle. With no stalls, data presented in cycle n appears on the outputs after edge n+1.
- Counters:
  - Unsigned; each saturates at 2^CNT_W-1 with no wrap.
  - retire_cnt adds up to LANES per cycle and clamps at max.
  - cnt_clr=1 zeroes all counters at the edge and overrides any increment in the same cycle.
  - cnt_clr does not affect the payload registers.
- Reset asserted mid-hold or mid-flush takes effect immediately (asynchronously). Deassertion is synchronised externally.

Test Plan:
1. Advance, LANES=2. valid_i=2'b11, kill_i=0, inst_addr_i={32'hBFC0_0004, 32'hBFC0_0000}, aluop_i=8'h21. Stall=0 -> next cycle valid_o=2'b11, inst_addr_o matches the inputs, aluop_o=8'h21, retire_cnt_o=2.
2. Bubble. stall=6'b000010 for one cycle (STAGE_IDX=1) -> valid_o=0, we_o=0, aluop_o=NOP_OP, bubble_cnt_o=1, retire_cnt_o unchanged.
3. Hold. stall=6'b000110 for 3 cycles while the inputs change -> outputs stay frozen at the previous capture and hold_cnt_o=3. Releasing the stall to 0 captures the current inputs.
4. Exception flush during hold. stall=6'b000110, flush=1, flush_cause=1 -> empty state next cycle, and hold_cnt and bubble_cnt are unchanged. Repeating with flush_cause=0 -> outputs held.
5. Kill and lane-0 binding. valid_i=2'b11, kill_i=2'b01, we_i=2'b11, whilo_i=1 -> valid_o=2'b10, we_o=2'b10, whilo_o=0, aluop_o=NOP_OP, retire_cnt_o increments by 1.
6. Saturation and clear, CNT_W=4. Run 20 advances with valid_i=2'b11 -> retire_cnt_o=15. Assert cnt_clr together with an advance -> retire_cnt_o=0 next cycle. Assert rst mid-run -> all outputs 0 immediately, aluop_o=NOP_OP.
